// File: rtl/bcd_display_scanner.sv
// Binary-to-BCD front end for the 4-digit common-anode display: double-dabble
// conversion into latched display registers, then a time-multiplexed digit scan.
module bcd_display_scanner #(
    parameter int CLK_DIV  = 50000,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] bin_in,
    input  logic        load,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an,
    output logic        busy,
    output logic        done,
    output logic        ovf
);

    localparam int RW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

    state_t         state, state_next;
    logic [13:0]    sat;
    logic [15:0]    acc;
    logic [15:0]    acc_adj;
    logic [3:0]     shift_cnt;
    logic           ovf_next;
    logic [3:0][3:0] disp;
    logic [RW-1:0]  refresh;
    logic [1:0]     idx;
    logic [3:0]     blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = CONV;
            CONV:    if (shift_cnt == 4'd13) state_next = LATCH;
            LATCH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 4; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat       <= '0;
            acc       <= '0;
            shift_cnt <= '0;
            ovf_next  <= 1'b0;
            disp      <= '0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        sat       <= (bin_in > 14'd9999) ? 14'd9999 : bin_in;
                        ovf_next  <= (bin_in > 14'd9999);
                        acc       <= '0;
                        shift_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end
                CONV: begin
                    acc       <= {acc_adj[14:0], sat[13]};
                    sat       <= {sat[12:0], 1'b0};
                    shift_cnt <= shift_cnt + 4'd1;
                end
                LATCH: begin
                    disp <= acc;
                    ovf  <= ovf_next;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // A digit is a leading zero when it and every higher digit are zero; digit 0 always shows.
    always_comb begin
        blank    = '0;
        blank[3] = BLANK_LZ && (disp[3] == 4'd0);
        blank[2] = blank[3] && (disp[2] == 4'd0);
        blank[1] = blank[2] && (disp[1] == 4'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh <= '0;
            idx     <= '0;
            an      <= 4'b1111;
            bcd_out <= 4'd0;
        end else begin
            if (refresh == RW'(CLK_DIV - 1)) begin
                refresh <= '0;
                idx     <= idx + 2'd1;
            end else begin
                refresh <= refresh + RW'(1);
            end
            an      <= blank[idx] ? 4'b1111 : ~(4'b0001 << idx);
            bcd_out <= disp[idx];
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner: two instances (plain and leading-zero
// blanking) share stimulus; a monitor checks each done pulse and the following scan.
module tb_bcd_display_scanner;

    localparam int CLK_DIV = 4;

    typedef struct packed {
        logic [15:0] digits;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [13:0] bin_in = '0;

    logic [3:0] bcd_a, an_a, bcd_b, an_b;
    logic       busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;

    int checks = 0;
    int errors = 0;
    exp_t sbq[$];

    bcd_display_scanner #(.CLK_DIV(CLK_DIV), .BLANK_LZ(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .load(load),
        .bcd_out(bcd_a), .an(an_a), .busy(busy_a), .done(done_a), .ovf(ovf_a)
    );

    bcd_display_scanner #(.CLK_DIV(CLK_DIV), .BLANK_LZ(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .load(load),
        .bcd_out(bcd_b), .an(an_b), .busy(busy_b), .done(done_b), .ovf(ovf_b)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic int countBlank(input logic [15:0] d);
        int n = 0;
        if (d[15:12] == 4'd0) n++;
        if (d[15:8]  == 8'd0) n++;
        if (d[15:4]  == 12'd0) n++;
        return n;
    endfunction

    task automatic issueLoad(input logic [13:0] value);
        bin_in = value;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic waitDone(input int expLat, input string tag);
        int n = 0;
        int busyCnt = 0;
        while (!done_a && n < 40) begin
            if (busy_a) busyCnt++;
            n++;
            @(negedge clk);
        end
        checkOutput({tag, "_latency"}, n, expLat);
        checkOutput({tag, "_busy_cycles"}, busyCnt, expLat);
        checkOutput({tag, "_busy_low_at_done"}, {31'd0, busy_a}, 32'd0);
    endtask

    task automatic applyStimulus(input logic [13:0] value, input logic [15:0] digits,
                                 input logic expOvf, input string tag);
        exp_t e;
        e.digits = digits;
        e.ovf    = expOvf;
        sbq.push_back(e);
        issueLoad(value);
        waitDone(15, tag);
        repeat (20) @(negedge clk);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_an_a"}, {28'd0, an_a}, 32'hf);
        checkOutput({tag, "_an_b"}, {28'd0, an_b}, 32'hf);
        checkOutput({tag, "_bcd"}, {28'd0, bcd_a}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done_a}, 32'd0);
        checkOutput({tag, "_ovf"}, {31'd0, ovf_a}, 32'd0);
    endtask

    // Monitor state: one done pulse pops one expectation and inspects a full scan period.
    exp_t        me;
    logic [15:0] got;
    logic [3:0]  prevAn;
    int          slotCnt[4];
    int          badAn, orderErr, holdErr, blankCnt, b0Cnt, b0Err, badB, doneInWin;

    always begin
        @(negedge clk);
        if (rst_n && done_a) begin
            checkOutput("done_b_aligned", {31'd0, done_b}, 32'd1);
            if (sbq.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                me = sbq.pop_front();
                checkOutput("ovf_a", {31'd0, ovf_a}, {31'd0, me.ovf});
                checkOutput("ovf_b", {31'd0, ovf_b}, {31'd0, me.ovf});
                got = '0; badAn = 0; orderErr = 0; holdErr = 0; blankCnt = 0;
                b0Cnt = 0; b0Err = 0; badB = 0; doneInWin = 0;
                prevAn = an_a;
                for (int k = 0; k < 4; k++) slotCnt[k] = 0;
                repeat (4 * CLK_DIV) begin
                    @(negedge clk);
                    if (done_a) doneInWin++;
                    case (an_a)
                        4'b1110: begin got[3:0]   = bcd_a; slotCnt[0]++; end
                        4'b1101: begin got[7:4]   = bcd_a; slotCnt[1]++; end
                        4'b1011: begin got[11:8]  = bcd_a; slotCnt[2]++; end
                        4'b0111: begin got[15:12] = bcd_a; slotCnt[3]++; end
                        default: badAn++;
                    endcase
                    if (an_a != prevAn && an_a != {prevAn[2:0], prevAn[3]}) orderErr++;
                    prevAn = an_a;
                    if (an_b == 4'b1111) blankCnt++;
                    else if (an_b == 4'b1110) begin
                        b0Cnt++;
                        if (bcd_b !== me.digits[3:0]) b0Err++;
                    end else if (!(an_b inside {4'b1101, 4'b1011, 4'b0111})) badB++;
                end
                for (int k = 0; k < 4; k++) if (slotCnt[k] != CLK_DIV) holdErr++;
                checkOutput("scan_digits", {16'd0, got}, {16'd0, me.digits});
                checkOutput("scan_an_onehot", badAn, 0);
                checkOutput("scan_order", orderErr, 0);
                checkOutput("scan_hold", holdErr, 0);
                checkOutput("done_single_cycle", doneInWin, 0);
                checkOutput("blank_slots", blankCnt, CLK_DIV * countBlank(me.digits));
                checkOutput("blank_digit0_shown", b0Cnt, CLK_DIV);
                checkOutput("blank_digit0_value", b0Err, 0);
                checkOutput("blank_an_legal", badB, 0);
            end
        end
    end

    initial begin
        int nz, dn;
        $display("[TB] start");
        repeat (3) @(negedge clk);
        checkResetState("reset_init");
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("first_after_reset_an", {28'd0, an_a}, 32'he);
        checkOutput("first_after_reset_bcd", {28'd0, bcd_a}, 32'd0);
        repeat (3) @(negedge clk);

        applyStimulus(14'd1234,  16'h1234, 1'b0, "load_1234");
        applyStimulus(14'd12000, 16'h9999, 1'b1, "load_12000");
        applyStimulus(14'd42,    16'h0042, 1'b0, "load_42");

        // Second load arrives mid-conversion and must be dropped.
        sbq.push_back('{digits: 16'h1234, ovf: 1'b0});
        issueLoad(14'd1234);
        repeat (4) @(negedge clk);
        issueLoad(14'd5678);
        waitDone(10, "busy_load");
        repeat (20) @(negedge clk);

        applyStimulus(14'd7,    16'h0007, 1'b0, "load_7");
        applyStimulus(14'd0,    16'h0000, 1'b0, "load_0");
        applyStimulus(14'd9999, 16'h9999, 1'b0, "load_9999");

        // Abort a conversion with reset; nothing from it may ever appear.
        issueLoad(14'd9999);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkResetState("reset_mid");
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("mid_release_an", {28'd0, an_a}, 32'he);
        checkOutput("mid_release_bcd", {28'd0, bcd_a}, 32'd0);
        nz = 0;
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (bcd_a != 4'd0) nz++;
            if (done_a) dn++;
        end
        checkOutput("aborted_display_zero", nz, 0);
        checkOutput("aborted_no_done", dn, 0);

        applyStimulus(14'd305, 16'h0305, 1'b0, "load_305");

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
